// File: rtl/flash_cmd_exec_sclk.sv
// SCLK-domain flash command executor: sequences READ/WRITE/ROW_WRITE/ERASE/MASS_ERASE
// onto a single-port word array with program/erase wait timers and level abort.
module flash_cmd_exec_sclk #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 10,
  parameter int unsigned ROW_LEN   = 8,
  parameter int unsigned PROG_CYC  = 4,
  parameter int unsigned ERASE_CYC = 6
) (
  input  logic              SCLK,
  input  logic              RESETn_sclk,
  input  logic              start_sclk,
  input  logic [2:0]        cmd_sclk,
  input  logic [ADDR_W-1:0] addr_sclk,
  input  logic [DATA_W-1:0] wdata_sclk,
  input  logic              abort_sclk,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy_sclk,
  output logic              done_sclk,
  output logic              resp_sclk,
  output logic [DATA_W-1:0] RDATA_sclk
);

  localparam int unsigned CNT_W    = ADDR_W + 1;
  localparam int unsigned WAIT_MAX = (PROG_CYC > ERASE_CYC) ? PROG_CYC : ERASE_CYC;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);

  localparam logic [ADDR_W-1:0] ROW_MASK  = ADDR_W'(ROW_LEN - 1);
  localparam logic [CNT_W-1:0]  ROW_LAST  = CNT_W'(ROW_LEN - 1);
  localparam logic [CNT_W-1:0]  MASS_LAST = CNT_W'((1 << ADDR_W) - 1);

  localparam logic [2:0] CMD_IDLE      = 3'd0;
  localparam logic [2:0] CMD_READ      = 3'd1;
  localparam logic [2:0] CMD_WRITE     = 3'd2;
  localparam logic [2:0] CMD_ROW_WRITE = 3'd3;
  localparam logic [2:0] CMD_ERASE     = 3'd4;
  localparam logic [2:0] CMD_MASS      = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_WR_STROBE, S_WR_WAIT, S_SWEEP, S_ER_WAIT, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                resp_q, resp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [CNT_W-1:0]    idx_nxt;
  logic [ADDR_W-1:0]   row_addr_nxt;
  logic [CNT_W-1:0]    sweep_last;

  // Row offset is masked so base+k stays inside the row; the counter is one bit
  // wider than the address so a full mass-erase sweep ends without aliasing.
  assign idx_nxt      = idx_q + CNT_W'(1);
  assign row_addr_nxt = (addr_q & ~ROW_MASK) | (ADDR_W'(idx_nxt) & ROW_MASK);
  assign sweep_last   = (cmd_q == CMD_MASS) ? MASS_LAST : ROW_LAST;

  always_ff @(posedge SCLK) begin
    if (!RESETn_sclk) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      idx_q       <= '0;
      wait_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      resp_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      resp_q      <= resp_d;
      rdata_q     <= rdata_d;
    end
  end

  // Outputs are computed for the state being entered so they register alongside it.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    resp_d      = resp_q;
    rdata_d     = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_sclk) begin
          cmd_d   = cmd_sclk;
          addr_d  = addr_sclk;
          wdata_d = wdata_sclk;
          idx_d   = '0;
          case (cmd_sclk)
            CMD_IDLE: state_d = S_IDLE;
            CMD_READ: begin
              state_d    = S_RD_ISSUE;
              mem_en_d   = 1'b1;
              mem_addr_d = addr_sclk;
            end
            CMD_WRITE: begin
              state_d     = S_WR_STROBE;
              mem_en_d    = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = addr_sclk;
              mem_wdata_d = wdata_sclk;
            end
            CMD_ROW_WRITE: begin
              state_d     = S_WR_STROBE;
              mem_en_d    = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = addr_sclk & ~ROW_MASK;
              mem_wdata_d = wdata_sclk;
            end
            CMD_ERASE: begin
              state_d     = S_SWEEP;
              mem_en_d    = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = addr_sclk & ~ROW_MASK;
              mem_wdata_d = '1;
            end
            CMD_MASS: begin
              state_d     = S_SWEEP;
              mem_en_d    = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = '0;
              mem_wdata_d = '1;
            end
            default: begin
              state_d = S_DONE;
              resp_d  = 1'b1;
            end
          endcase
        end
      end

      S_RD_ISSUE: state_d = S_RD_WAIT;

      S_RD_WAIT: begin
        rdata_d = mem_rdata;
        state_d = S_DONE;
        resp_d  = 1'b0;
      end

      S_WR_STROBE: begin
        if (abort_sclk) begin
          state_d = S_DONE;
          resp_d  = 1'b1;
        end else begin
          state_d = S_WR_WAIT;
          wait_d  = WAIT_W'(PROG_CYC - 1);
        end
      end

      S_WR_WAIT: begin
        if (abort_sclk) begin
          state_d = S_DONE;
          resp_d  = 1'b1;
        end else if (wait_q != '0) begin
          wait_d = wait_q - WAIT_W'(1);
        end else if (cmd_q == CMD_ROW_WRITE && idx_q != ROW_LAST) begin
          state_d     = S_WR_STROBE;
          idx_d       = idx_nxt;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = row_addr_nxt;
          mem_wdata_d = wdata_q;
        end else begin
          state_d = S_DONE;
          resp_d  = 1'b0;
        end
      end

      S_SWEEP: begin
        if (abort_sclk) begin
          state_d = S_DONE;
          resp_d  = 1'b1;
        end else if (idx_q == sweep_last) begin
          state_d = S_ER_WAIT;
          wait_d  = WAIT_W'(ERASE_CYC - 1);
        end else begin
          idx_d       = idx_nxt;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = (cmd_q == CMD_MASS) ? ADDR_W'(idx_nxt) : row_addr_nxt;
          mem_wdata_d = '1;
        end
      end

      S_ER_WAIT: begin
        if (abort_sclk) begin
          state_d = S_DONE;
          resp_d  = 1'b1;
        end else if (wait_q != '0) begin
          wait_d = wait_q - WAIT_W'(1);
        end else begin
          state_d = S_DONE;
          resp_d  = 1'b0;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy_sclk  = busy_q;
  assign done_sclk  = done_q;
  assign resp_sclk  = resp_q;
  assign RDATA_sclk = rdata_q;

endmodule

// File: tb/tb_flash_cmd_exec_sclk.sv
// Bench for flash_cmd_exec_sclk: directed and random commands checked against a
// strobe-list model built from the command timing rules.
module tb_flash_cmd_exec_sclk;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DATA_W    = 10;
  localparam int unsigned ROW_LEN   = 8;
  localparam int unsigned PROG_CYC  = 4;
  localparam int unsigned ERASE_CYC = 6;
  localparam int          DEPTH     = 1 << ADDR_W;

  logic              SCLK = 1'b0;
  logic              RESETn_sclk;
  logic              start_sclk;
  logic [2:0]        cmd_sclk;
  logic [ADDR_W-1:0] addr_sclk;
  logic [DATA_W-1:0] wdata_sclk;
  logic              abort_sclk;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy_sclk;
  logic              done_sclk;
  logic              resp_sclk;
  logic [DATA_W-1:0] RDATA_sclk;

  always #5 SCLK = ~SCLK;

  flash_cmd_exec_sclk #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROW_LEN(ROW_LEN),
    .PROG_CYC(PROG_CYC), .ERASE_CYC(ERASE_CYC)
  ) dut (
    .SCLK(SCLK), .RESETn_sclk(RESETn_sclk), .start_sclk(start_sclk), .cmd_sclk(cmd_sclk),
    .addr_sclk(addr_sclk), .wdata_sclk(wdata_sclk), .abort_sclk(abort_sclk),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy_sclk(busy_sclk), .done_sclk(done_sclk),
    .resp_sclk(resp_sclk), .RDATA_sclk(RDATA_sclk)
  );

  // Word array behind the memory port, with a bench-side preload path.
  logic [DATA_W-1:0] mem [DEPTH];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;

  always @(posedge SCLK) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] data;
  } strobe_t;

  strobe_t           exp_q[$];
  strobe_t           act_q[$];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                exp_D;
  logic              exp_resp_now;
  logic              exp_resp_h  = 1'b0;
  logic [DATA_W-1:0] exp_rdata_h = '0;
  int                n_checks = 0;
  int                n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_exp(input int cyc, input int a, input logic we, input int d);
    strobe_t s;
    s.cyc  = cyc;
    s.addr = ADDR_W'(a);
    s.we   = we;
    s.data = DATA_W'(d);
    exp_q.push_back(s);
  endfunction

  // Expected strobes and completion cycle, from the per-command timing rules.
  task automatic build_exp(input int cmd, input int addr, input int wdata);
    int base;
    int ones;
    base = addr & ~(ROW_LEN - 1) & (DEPTH - 1);
    ones = (1 << DATA_W) - 1;
    exp_q.delete();
    exp_resp_now = 1'b0;
    case (cmd)
      1: begin push_exp(1, addr, 1'b0, 0); exp_D = 3; end
      2: begin push_exp(1, addr, 1'b1, wdata); exp_D = PROG_CYC + 2; end
      3: begin
        for (int k = 0; k < ROW_LEN; k++) push_exp(1 + k * (PROG_CYC + 1), base + k, 1'b1, wdata);
        exp_D = ROW_LEN * (PROG_CYC + 1) + 1;
      end
      4: begin
        for (int k = 0; k < ROW_LEN; k++) push_exp(1 + k, base + k, 1'b1, ones);
        exp_D = ROW_LEN + ERASE_CYC + 1;
      end
      5: begin
        for (int a = 0; a < DEPTH; a++) push_exp(1 + a, a, 1'b1, ones);
        exp_D = DEPTH + ERASE_CYC + 1;
      end
      6, 7: begin exp_D = 1; exp_resp_now = 1'b1; end
      default: exp_D = -1;
    endcase
  endtask

  task automatic apply_abort(input int cmd, input int ab);
    if (cmd >= 2 && cmd <= 5 && ab >= 1 && ab <= exp_D - 1) begin
      exp_D        = ab + 1;
      exp_resp_now = 1'b1;
      while (exp_q.size() > 0 && exp_q[$].cyc > ab) void'(exp_q.pop_back());
    end
  endtask

  task automatic drive_idle();
    start_sclk = 1'b0;
    abort_sclk = 1'b0;
    cmd_sclk   = 3'd0;
  endtask

  // One command from its start cycle through its DONE cycle; ab/sc = abort and
  // extra-start cycles (-1 for none), xcmd = command carried by the extra start.
  task automatic run_cmd(input int cmd, input int addr, input int wdata,
                         input int ab, input int sc, input int xcmd);
    logic [DATA_W-1:0] new_rdata;
    logic              new_resp;
    int                run_len;
    int                sc_eff;
    strobe_t           s;
    build_exp(cmd, addr, wdata);
    apply_abort(cmd, ab);
    new_rdata = (cmd == 1) ? ref_mem[addr] : exp_rdata_h;
    new_resp  = (exp_D > 0) ? exp_resp_now : exp_resp_h;
    run_len   = (exp_D > 0) ? exp_D : 4;
    sc_eff    = (sc >= 1 && sc <= exp_D) ? sc : -1;
    act_q.delete();
    for (int c = 0; c <= run_len; c++) begin
      @(posedge SCLK); #1;
      start_sclk = (c == 0) || (c == sc_eff);
      cmd_sclk   = (c == 0) ? 3'(cmd) : 3'(xcmd);
      addr_sclk  = (c == 0) ? ADDR_W'(addr) : ADDR_W'($urandom);
      wdata_sclk = (c == 0) ? DATA_W'(wdata) : DATA_W'($urandom);
      abort_sclk = (c == ab);
      @(negedge SCLK);
      if (mem_en) begin
        s.cyc = c; s.addr = mem_addr; s.we = mem_we; s.data = mem_wdata;
        act_q.push_back(s);
      end
      check($sformatf("busy cmd%0d c%0d", cmd, c), 32'(busy_sclk), 32'(c >= 1 && c <= exp_D));
      check($sformatf("done cmd%0d c%0d", cmd, c), 32'(done_sclk), 32'(c == exp_D));
      if (c == 0) begin
        check("resp_hold", 32'(resp_sclk), 32'(exp_resp_h));
        check("rdata_hold", 32'(RDATA_sclk), 32'(exp_rdata_h));
      end
      if (c == exp_D) begin
        check($sformatf("resp cmd%0d", cmd), 32'(resp_sclk), 32'(new_resp));
        check($sformatf("rdata cmd%0d", cmd), 32'(RDATA_sclk), 32'(new_rdata));
      end
    end
    check($sformatf("strobe_count cmd%0d", cmd), 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      check($sformatf("strobe%0d_cyc", i), 32'(act_q[i].cyc), 32'(exp_q[i].cyc));
      check($sformatf("strobe%0d_addr", i), 32'(act_q[i].addr), 32'(exp_q[i].addr));
      check($sformatf("strobe%0d_we", i), 32'(act_q[i].we), 32'(exp_q[i].we));
      if (exp_q[i].we) check($sformatf("strobe%0d_data", i), 32'(act_q[i].data), 32'(exp_q[i].data));
    end
    foreach (exp_q[i]) if (exp_q[i].we) ref_mem[exp_q[i].addr] = exp_q[i].data;
    exp_resp_h  = new_resp;
    exp_rdata_h = new_rdata;
  endtask

  initial begin
    int cmd, ab, sc;
    logic [DATA_W-1:0] v;
    RESETn_sclk = 1'b0;
    addr_sclk   = '0;
    wdata_sclk  = '0;
    drive_idle();

    // Preload the array during reset.
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge SCLK); #1;
      v = (i == 'h155) ? DATA_W'('h2AA) : DATA_W'($urandom);
      pre_we = 1'b1; pre_addr = ADDR_W'(i); pre_data = v;
      ref_mem[i] = v;
    end
    @(posedge SCLK); #1;
    pre_we = 1'b0;
    @(negedge SCLK);
    check("rst_busy", 32'(busy_sclk), 32'd0);
    check("rst_done", 32'(done_sclk), 32'd0);
    check("rst_resp", 32'(resp_sclk), 32'd0);
    check("rst_rdata", 32'(RDATA_sclk), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge SCLK); #1;
    RESETn_sclk = 1'b1;

    run_cmd(1, 'h155, 0, -1, -1, 0);
    run_cmd(3, 'h00B, 'h0F0, -1, -1, 0);
    run_cmd(1, 'h00D, 0, -1, -1, 0);
    run_cmd(4, 'h3FD, 0, -1, -1, 0);
    run_cmd(1, 'h3FA, 0, -1, -1, 0);
    run_cmd(5, 0, 0, 100, -1, 0);
    run_cmd(2, 'h123, 'h055, -1, 2, 1);
    run_cmd(7, 'h200, 0, -1, -1, 0);
    run_cmd(1, 'h123, 0, 2, -1, 0);
    run_cmd(0, 'h010, 'h011, 1, -1, 0);

    // Reset in the middle of a row write: nothing resumes, no done pulse.
    build_exp(3, 'h00B, 'h1C3);
    while (exp_q.size() > 0 && exp_q[$].cyc > 3) void'(exp_q.pop_back());
    for (int c = 0; c <= 3; c++) begin
      @(posedge SCLK); #1;
      start_sclk = (c == 0); cmd_sclk = 3'd3; addr_sclk = ADDR_W'('h00B); wdata_sclk = DATA_W'('h1C3);
      RESETn_sclk = (c != 3);
    end
    @(posedge SCLK); #1;
    RESETn_sclk = 1'b1;
    drive_idle();
    @(negedge SCLK);
    check("midrst_busy", 32'(busy_sclk), 32'd0);
    check("midrst_mem_en", 32'(mem_en), 32'd0);
    check("midrst_done", 32'(done_sclk), 32'd0);
    check("midrst_resp", 32'(resp_sclk), 32'd0);
    check("midrst_rdata", 32'(RDATA_sclk), 32'd0);
    for (int c = 5; c < 50; c++) begin
      @(negedge SCLK);
      check($sformatf("midrst_quiet c%0d", c), 32'({done_sclk, busy_sclk, mem_en}), 32'd0);
    end
    foreach (exp_q[i]) ref_mem[exp_q[i].addr] = exp_q[i].data;
    exp_resp_h  = 1'b0;
    exp_rdata_h = '0;
    run_cmd(1, 'h008, 0, -1, -1, 0);
    run_cmd(1, 'h009, 0, -1, -1, 0);

    // Random command mix with stray starts and aborts.
    for (int n = 0; n < 40; n++) begin
      cmd = int'($urandom_range(0, 7));
      if (cmd == 5 && $urandom_range(0, 3) != 0) cmd = 4;
      ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 45)) : -1;
      sc  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 12)) : -1;
      run_cmd(cmd, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, (1 << DATA_W) - 1)),
              ab, sc, int'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) run_cmd(1, int'($urandom_range(0, DEPTH - 1)), 0, -1, -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
